// File: rtl/scope_trig_capture_if.sv
// Sample-in and frame-readout signals shared between the filter/readout side and the capture block.
interface scope_trig_capture_if #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 10
);
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [DATA_SIZE-1:0] rd_data;

  modport master (
    output in_valid,
    output in_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/scope_trig_capture.sv
// Edge-triggered frame capture into a ring buffer with random-access readout of the held frame.
module scope_trig_capture #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 trig_edge,
  input  logic [DATA_SIZE-1:0] trig_level,
  input  logic [ADDR_SIZE-1:0] pre_len,
  input  logic                 force_trig,
  scope_trig_capture_if.slave  bus,
  output logic                 busy,
  output logic                 triggered,
  output logic                 frame_ready,
  output logic [ADDR_SIZE-1:0] trig_index
);

  localparam int DEPTH = 2 ** ADDR_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    READY
  } state_t;

  state_t state, next_state;

  logic                 cfg_edge;
  logic [DATA_SIZE-1:0] cfg_level;
  logic [ADDR_SIZE-1:0] cfg_pre;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] trig_ptr;
  logic [ADDR_SIZE-1:0] cnt;
  logic [ADDR_SIZE-1:0] cnt_inc;
  logic [ADDR_SIZE-1:0] post_len;
  logic [ADDR_SIZE-1:0] start_ptr;
  logic [DATA_SIZE-1:0] prev;
  logic                 prev_valid;
  logic                 force_pend;

  logic                 acquiring;
  logic                 wr_en;
  logic                 cross_hit;
  logic                 trig_hit;
  logic                 post_done;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // pre_len is ADDR_SIZE wide, so it can never exceed DEPTH-1 and the clamp is implicit.
  // With DEPTH-1 all ones, DEPTH-1-pre_len is simply the bitwise complement.
  assign post_len   = ~cfg_pre;
  assign cnt_inc    = ADDR_SIZE'(cnt + 1'b1);
  assign start_ptr  = ADDR_SIZE'(trig_ptr - cfg_pre);
  assign trig_index = cfg_pre;

  assign acquiring = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
  assign wr_en     = acquiring && bus.in_valid && !arm;
  assign cross_hit = cfg_edge ? ((prev > cfg_level) && (bus.in_data <= cfg_level))
                              : ((prev < cfg_level) && (bus.in_data >= cfg_level));
  assign trig_hit  = (state == WAIT_TRIG) && wr_en && (force_pend || (prev_valid && cross_hit));
  assign post_done = (state == POST) && wr_en && (cnt_inc == post_len);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; arm overrides every state.
  always_comb begin
    next_state = state;
    if (arm) begin
      next_state = PREFILL;
    end else begin
      unique case (state)
        IDLE:      next_state = IDLE;
        PREFILL:   if (cnt == cfg_pre) next_state = WAIT_TRIG;
        WAIT_TRIG: if (trig_hit) next_state = (post_len == '0) ? READY : POST;
        POST:      if (post_done) next_state = READY;
        READY:     next_state = READY;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy        = 1'b0;
    triggered   = 1'b0;
    frame_ready = 1'b0;
    unique case (state)
      PREFILL, WAIT_TRIG: busy = 1'b1;
      POST: begin
        busy      = 1'b1;
        triggered = 1'b1;
      end
      READY: begin
        triggered   = 1'b1;
        frame_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Configuration, pointers, sample counter, previous-sample tracking and force flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_edge   <= 1'b0;
      cfg_level  <= '0;
      cfg_pre    <= '0;
      wr_ptr     <= '0;
      trig_ptr   <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
    end else if (arm) begin
      cfg_edge   <= trig_edge;
      cfg_level  <= trig_level;
      cfg_pre    <= pre_len;
      wr_ptr     <= '0;
      cnt        <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr     <= ADDR_SIZE'(wr_ptr + 1'b1);
        prev       <= bus.in_data;
        prev_valid <= 1'b1;
      end
      if (force_trig && acquiring) force_pend <= 1'b1;
      if (trig_hit) begin
        force_pend <= 1'b0;
        trig_ptr   <= wr_ptr;
        cnt        <= '0;
      end else if (wr_en && ((state == PREFILL) || (state == POST))) begin
        cnt <= cnt_inc;
      end
    end
  end

  // Ring-buffer write and frame-relative registered read; memory is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
    bus.rd_data <= mem[ADDR_SIZE'(start_ptr + bus.rd_addr)];
  end

endmodule

// File: tb/tb_scope_trig_capture.sv
// Directed bench for scope_trig_capture (DEPTH = 16) with a readout scoreboard.
module tb_scope_trig_capture;

  localparam int DS = 16;
  localparam int AS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          trig_edge = 1'b0;
  logic [DS-1:0] trig_level = '0;
  logic [AS-1:0] pre_len = '0;
  logic          force_trig = 1'b0;
  logic          busy, triggered, frame_ready;
  logic [AS-1:0] trig_index;

  logic          rd_req = 1'b0;
  logic          rd_req_q = 1'b0;
  int            exp_q[$];
  int            checks = 0;
  int            errors = 0;

  scope_trig_capture_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) bus ();

  scope_trig_capture #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .trig_edge   (trig_edge),
    .trig_level  (trig_level),
    .pre_len     (pre_len),
    .force_trig  (force_trig),
    .bus         (bus),
    .busy        (busy),
    .triggered   (triggered),
    .frame_ready (frame_ready),
    .trig_index  (trig_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A read issued at one edge has its data on rd_data after the next edge.
  always @(posedge clk) rd_req_q <= rd_req;

  always @(negedge clk) begin
    if (rd_req_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: got %0d with no expected value queued", bus.rd_data);
      end else begin
        chk("rd_data", int'(bus.rd_data), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = DS'(d);
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic do_arm(input logic e, input int lvl, input int pre);
    trig_edge  = e;
    trig_level = DS'(lvl);
    pre_len    = AS'(pre);
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    trig_level = '1;
    pre_len    = '1;
    trig_edge  = ~e;
  endtask

  task automatic read_at(input int a, input int exp);
    bus.rd_addr = AS'(a);
    rd_req      = 1'b1;
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic read_done();
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic status(input string tag, input int b, input int t, input int f);
    chk({tag, " busy"}, int'(busy), b);
    chk({tag, " triggered"}, int'(triggered), t);
    chk({tag, " frame_ready"}, int'(frame_ready), f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_addr  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    status("reset", 0, 0, 0);
    chk("reset trig_index", int'(trig_index), 0);
    send(77);
    status("idle ignores samples", 0, 0, 0);

    // Rising ramp, level 100, pre 4.
    do_arm(1'b0, 100, 4);
    status("armed", 1, 0, 0);
    for (int i = 0; i <= 200; i += 10) send(i);
    status("ramp before last", 1, 1, 0);
    send(210);
    status("ramp done", 0, 1, 1);
    chk("ramp trig_index", int'(trig_index), 4);
    for (int i = 220; i <= 300; i += 10) send(i);
    for (int a = 0; a < 16; a++) read_at(a, 60 + 10 * a);
    read_done();

    // Falling, level 50, pre 0: 80,60,50 triggers on 50; 40,60 afterwards do not retrigger.
    do_arm(1'b1, 50, 0);
    send(80);
    send(60);
    status("fall before", 1, 0, 0);
    send(50);
    status("fall trig", 1, 1, 0);
    send(40);
    send(60);
    for (int i = 1; i <= 13; i++) send(i);
    status("fall done", 0, 1, 1);
    chk("fall trig_index", int'(trig_index), 0);
    read_at(0, 50);
    read_at(1, 40);
    read_at(2, 60);
    read_at(15, 13);
    read_done();

    // Force trigger during PREFILL on a flat signal.
    do_arm(1'b0, 100, 4);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    for (int i = 0; i < 4; i++) send(20);
    status("force prefill", 1, 0, 0);
    send(20);
    status("force trig", 1, 1, 0);
    for (int i = 0; i < 11; i++) send(20);
    status("force done", 0, 1, 1);
    for (int a = 0; a < 16; a += 5) read_at(a, 20);
    read_done();

    // Ring overrun: 40 samples wait for the trigger.
    do_arm(1'b0, 100, 4);
    for (int i = 0; i < 4; i++) send(0);
    for (int i = 1; i <= 40; i++) send(i);
    status("overrun wait", 1, 0, 0);
    send(200);
    for (int i = 0; i < 11; i++) send(300 + i);
    status("overrun done", 0, 1, 1);
    for (int a = 0; a < 4; a++) read_at(a, 37 + a);
    read_at(4, 200);
    read_at(5, 300);
    read_at(15, 310);
    read_done();

    // Reset in the middle of POST.
    do_arm(1'b0, 5, 0);
    send(0);
    send(10);
    status("pre reset", 1, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    status("after reset", 0, 0, 0);
    for (int i = 0; i < 3; i++) send(100 + i);
    status("after reset samples", 0, 0, 0);

    // Re-arm during POST with a coincident sample: the sample is dropped.
    do_arm(1'b0, 50, 2);
    send(10);
    send(20);
    send(30);
    send(60);
    send(70);
    status("first acq post", 1, 1, 0);
    trig_edge  = 1'b0;
    trig_level = DS'(50);
    pre_len    = AS'(2);
    arm          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DS'(999);
    tick();
    arm          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    status("rearm", 1, 0, 0);
    send(5);
    send(15);
    send(25);
    send(55);
    for (int i = 0; i < 12; i++) send(100 + i);
    status("rearm before last", 1, 1, 0);
    send(112);
    status("rearm done", 0, 1, 1);
    chk("rearm trig_index", int'(trig_index), 2);
    read_at(0, 15);
    read_at(1, 25);
    read_at(2, 55);
    read_at(3, 100);
    read_at(15, 112);
    read_done();

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
